// File: rtl/fpcvt_arbiter.sv
// Round-robin arbiter sharing one combinational FPCVT converter between requesters A and B,
// with a registered operand and a registered response held until the owner accepts it.
module fpcvt_arbiter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req_valid,
  input  logic [12:0]      a_req_data,
  output logic             a_req_ready,
  input  logic             b_req_valid,
  input  logic [12:0]      b_req_data,
  output logic             b_req_ready,
  output logic             a_rsp_valid,
  input  logic             a_rsp_ready,
  output logic             b_rsp_valid,
  input  logic             b_rsp_ready,
  output logic             rsp_s,
  output logic [2:0]       rsp_e,
  output logic [4:0]       rsp_f,
  output logic             busy,
  output logic [CNT_W-1:0] a_done_cnt,
  output logic [CNT_W-1:0] b_done_cnt,
  output logic [CNT_W-1:0] sat_cnt
);

  typedef enum logic [1:0] {StIdle, StConv, StResp} state_e;

  state_e      state_q, state_d;
  logic        ptr_q;    // 0: A has priority, 1: B has priority
  logic        owner_q;  // 0: A owns the transaction, 1: B
  logic [12:0] op_q;

  logic grant_a, grant_b, accept, rsp_fire;

  assign grant_a  = a_req_valid && (!b_req_valid || !ptr_q);
  assign grant_b  = b_req_valid && (!a_req_valid || ptr_q);
  assign accept   = (state_q == StIdle) && (grant_a || grant_b);
  assign rsp_fire = (state_q == StResp) && (owner_q ? b_rsp_ready : a_rsp_ready);

  // FPCVT: magnitude, leading-zero count, 5-bit significand with half-up rounding
  logic [12:0] neg;
  logic [11:0] mag, sh;
  logic [3:0]  lz, e_w;
  logic [5:0]  f_rnd;
  logic [2:0]  cv_e;
  logic [4:0]  cv_f;
  logic        cv_sat;

  always_comb begin
    neg = -op_q;
    if (op_q[12]) mag = (op_q == 13'h1000) ? 12'hfff : neg[11:0];
    else          mag = op_q[11:0];
    lz = 4'd12;
    for (int i = 0; i < 12; i++) begin
      if (mag[i]) lz = 4'(11 - i);
    end
    sh    = '0;
    f_rnd = '0;
    e_w   = '0;
    cv_e  = '0;
    cv_f  = mag[4:0];
    if (lz < 4'd7) begin
      e_w   = 4'd7 - lz;
      sh    = mag >> (e_w - 4'd1);
      f_rnd = {1'b0, sh[5:1]} + {5'd0, sh[0]};
      if (f_rnd[5]) begin
        e_w   = e_w + 4'd1;
        f_rnd = 6'd16;
      end
      if (e_w > 4'd7) begin
        cv_e = 3'd7;
        cv_f = 5'd31;
      end else begin
        cv_e = e_w[2:0];
        cv_f = f_rnd[4:0];
      end
    end
    cv_sat = (cv_e == 3'd7) && (cv_f == 5'd31);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StConv;
      StConv:  state_d = StResp;
      StResp:  if (rsp_fire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Readies are gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    a_req_ready = 1'b0;
    b_req_ready = 1'b0;
    a_rsp_valid = 1'b0;
    b_rsp_valid = 1'b0;
    busy        = (state_q != StIdle);
    if (state_q == StIdle) begin
      a_req_ready = rst_n && grant_a;
      b_req_ready = rst_n && grant_b;
    end
    if (state_q == StResp) begin
      a_rsp_valid = !owner_q;
      b_rsp_valid = owner_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      owner_q    <= 1'b0;
      ptr_q      <= 1'b0;
      rsp_s      <= 1'b0;
      rsp_e      <= '0;
      rsp_f      <= '0;
      a_done_cnt <= '0;
      b_done_cnt <= '0;
      sat_cnt    <= '0;
    end else begin
      if (accept) begin
        op_q    <= grant_b ? b_req_data : a_req_data;
        owner_q <= grant_b;
        ptr_q   <= !grant_b;
      end
      if (state_q == StConv) begin
        rsp_s <= op_q[12];
        rsp_e <= cv_e;
        rsp_f <= cv_f;
        if (cv_sat) sat_cnt <= sat_cnt + 1'b1;
      end
      if (rsp_fire) begin
        if (owner_q) b_done_cnt <= b_done_cnt + 1'b1;
        else         a_done_cnt <= a_done_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpcvt_arbiter.sv
// Directed self-checking bench for fpcvt_arbiter: handshake, arbitration, conversion and counters.
module tb_fpcvt_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req_valid, b_req_valid, a_req_ready, b_req_ready;
  logic [12:0] a_req_data, b_req_data;
  logic        a_rsp_valid, b_rsp_valid, a_rsp_ready, b_rsp_ready;
  logic        rsp_s, busy;
  logic [2:0]  rsp_e;
  logic [4:0]  rsp_f;
  logic [7:0]  a_done_cnt, b_done_cnt, sat_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fpcvt_arbiter #(.CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_req_valid (a_req_valid),
    .a_req_data  (a_req_data),
    .a_req_ready (a_req_ready),
    .b_req_valid (b_req_valid),
    .b_req_data  (b_req_data),
    .b_req_ready (b_req_ready),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_ready (a_rsp_ready),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_ready (b_rsp_ready),
    .rsp_s       (rsp_s),
    .rsp_e       (rsp_e),
    .rsp_f       (rsp_f),
    .busy        (busy),
    .a_done_cnt  (a_done_cnt),
    .b_done_cnt  (b_done_cnt),
    .sat_cnt     (sat_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  // One full transaction; caller holds the requester's rsp_ready high. Starts/ends just after posedge.
  task automatic txn(input bit is_b, input logic [12:0] d, input logic es, input logic [2:0] ee,
                     input logic [4:0] ef, input string tag);
    int n;
    if (is_b) begin b_req_valid = 1'b1; b_req_data = d; end
    else      begin a_req_valid = 1'b1; a_req_data = d; end
    n = 0;
    @(negedge clk);
    while (!(is_b ? b_req_ready : a_req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, 32'(is_b ? b_req_ready : a_req_ready), 32'd1);
    step();
    if (is_b) b_req_valid = 1'b0;
    else      a_req_valid = 1'b0;
    @(negedge clk);
    check({tag, "_conv_busy"}, 32'(busy), 32'd1);
    check({tag, "_conv_novalid"}, 32'(is_b ? b_rsp_valid : a_rsp_valid), 32'd0);
    step();
    @(negedge clk);
    check({tag, "_rsp_valid"}, 32'(is_b ? b_rsp_valid : a_rsp_valid), 32'd1);
    check({tag, "_rsp_sef"}, {23'd0, rsp_s, rsp_e, rsp_f}, {23'd0, es, ee, ef});
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [12:0] op;
    int          n;
    bit          who;
    rst_n = 1'b0;
    a_req_valid = 0; b_req_valid = 0; a_req_data = '0; b_req_data = '0;
    a_rsp_ready = 0; b_rsp_ready = 0;

    // Reset state and single request
    #3;
    check("rst_outputs", {busy, a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, rsp_s, rsp_e,
          rsp_f}, '0);
    check("rst_counters", {a_done_cnt, b_done_cnt, sat_cnt}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;
    txn(1'b0, 13'd100, 1'b0, 3'd2, 5'd25, "single_a");
    @(negedge clk);
    check("single_busy_falls", 32'(busy), 32'd0);
    check("single_a_done", 32'(a_done_cnt), 32'd1);
    check("single_b_done", 32'(b_done_cnt), 32'd0);
    step();

    // Contention: alternating grants starting with A after reset
    reset_pulse();
    op = -13'sd400;
    a_req_valid = 1'b1; a_req_data = op;
    b_req_valid = 1'b1; b_req_data = 13'd50;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      @(negedge clk);
      while (!(a_req_ready || b_req_ready) && n < 20) begin
        @(negedge clk);
        n++;
      end
      who = b_req_ready;
      check("cont_grant_order", 32'(who), 32'(i % 2));
      check("cont_single_grant", 32'(a_req_ready && b_req_ready), 32'd0);
      step();
      step();
      @(negedge clk);
      if (i % 2 == 0) begin
        check("cont_a_valid", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd2);
        check("cont_a_sef", {23'd0, rsp_s, rsp_e, rsp_f}, {23'd0, 1'b1, 3'd4, 5'd25});
      end else begin
        check("cont_b_valid", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd1);
        check("cont_b_sef", {23'd0, rsp_s, rsp_e, rsp_f}, {23'd0, 1'b0, 3'd1, 5'd25});
      end
      step();
    end
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    @(negedge clk);
    check("cont_done_cnts", {16'd0, a_done_cnt, b_done_cnt}, {16'd0, 8'd2, 8'd2});
    step();

    // Saturation
    txn(1'b1, 13'd4095, 1'b0, 3'd7, 5'd31, "sat_pos");
    txn(1'b1, 13'h1000, 1'b1, 3'd7, 5'd31, "sat_neg");
    @(negedge clk);
    check("sat_cnt", 32'(sat_cnt), 32'd2);
    step();

    // Backpressure: A held in RESP while B waits
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_req_data = 13'b0000000001111;
    b_req_valid = 1'b1; b_req_data = 13'd50;
    @(negedge clk);
    check("bp_a_grant", {30'd0, a_req_ready, b_req_ready}, 32'd2);
    step();
    a_req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_b_blocked", 32'(b_req_ready), 32'd0);
      if (i > 0) begin
        check("bp_hold", {22'd0, a_rsp_valid, rsp_s, rsp_e, rsp_f},
              {22'd0, 1'b1, 1'b0, 3'd0, 5'd15});
      end
      step();
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(a_rsp_valid), 32'd1);
    step();
    @(negedge clk);
    check("bp_b_granted", 32'(b_req_ready), 32'd1);
    txn(1'b1, 13'd50, 1'b0, 3'd1, 5'd25, "bp_b");

    // Reset during CONV with the pointer on B
    a_req_valid = 1'b1; a_req_data = 13'd100;
    @(negedge clk);
    check("mid_a_accept", 32'(a_req_ready), 32'd1);
    step();
    a_req_valid = 1'b0;
    b_req_valid = 1'b1; b_req_data = 13'd50;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {busy, a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, rsp_s,
          rsp_e, rsp_f}, '0);
    check("mid_rst_counters", {a_done_cnt, b_done_cnt, sat_cnt}, '0);
    a_req_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_post_grant", {30'd0, a_req_ready, b_req_ready}, 32'd2);
    step();
    a_req_valid = 1'b0;
    step();
    @(negedge clk);
    check("mid_post_rsp", {21'd0, a_rsp_valid, b_rsp_valid, rsp_s, rsp_e, rsp_f},
          {21'd0, 1'b1, 1'b0, 1'b0, 3'd2, 5'd25});
    step();
    b_req_valid = 1'b0;

    // Counter wrap
    reset_pulse();
    txn(1'b1, 13'd0, 1'b0, 3'd0, 5'd0, "wrap_b");
    for (int i = 0; i < 256; i++) begin
      txn(1'b0, 13'd0, 1'b0, 3'd0, 5'd0, "wrap_a");
    end
    @(negedge clk);
    check("wrap_a_done", 32'(a_done_cnt), 32'd0);
    check("wrap_b_done", 32'(b_done_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpcvt_arbiter.md
Name: fpcvt_arbiter

Overview:
- Shares one combinational FPCVT converter (13-bit two's-complement D in; S, 3-bit E, 5-bit F out) between two requesters, A and B.
- Arbitration is round-robin with a valid/ready handshake on each request and response channel.
- The operand is registered into the converter, and the converted result is held on a registered response bus until the owning requester accepts it.
- Per-requester completion counters and a saturation counter support on-board debug (seven-segment and LED readout).

Parameters:
- CNT_W, 8, width of the completion and saturation counters (wrap modulo 2^CNT_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req_valid  in  1  requester A has an operand.
- a_req_data  in  13  requester A operand, two's complement.
- a_req_ready  out  1  arbiter accepts A's operand this cycle.
- b_req_valid  in  1  requester B has an operand.
- b_req_data  in  13  requester B operand.
- b_req_ready  out  1  arbiter accepts B's operand this cycle.
- a_rsp_valid  out  1  result for A is on rsp_s/rsp_e/rsp_f.
- a_rsp_ready  in  1  A takes the result.
- b_rsp_valid  out  1  result for B is on the bus.
- b_rsp_ready  in  1  B takes the result.
- rsp_s  out  1  registered sign.
- rsp_e  out  3  registered exponent.
- rsp_f  out  5  registered significand.
- busy  out  1  FSM is not IDLE.
- a_done_cnt  out  CNT_W  count of completed A transactions.
- b_done_cnt  out  CNT_W  count of completed B transactions.
- sat_cnt  out  CNT_W  count of results equal to E=7, F=31.

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE.
  - All ready/valid outputs are 0; busy is 0.
  - rsp_s/e/f, operand register, owner flag and all counters are 0.
  - The priority pointer points to A.
  - An assertion mid-transaction aborts it; the operand is lost and no response is issued.
- FSM states IDLE, CONV, RESP.
- IDLE:
  - Grant, combinational from valids and the pointer:
    - If only one requester is valid, that requester is granted.
    - If both are valid, the requester selected by the pointer is granted.
  - The granted requester's req_ready is 1 in IDLE only, so the accept fires in the same cycle as valid.
  - On accept: latch the operand into op_reg, record the owner, flip the pointer to the other requester, and go to CONV.
  - With no valid request, stay in IDLE.
- CONV (exactly 1 cycle):
  - op_reg drives FPCVT.D.
  - At the end of the cycle, FPCVT outputs are registered into rsp_s/e/f.
  - sat_cnt increments if E=7 and F=31.
  - Go to RESP.
- RESP:
  - The owner's rsp_valid is 1 and the other requester's rsp_valid is 0.
  - rsp_s/e/f are stable until the handshake completes.
  - On owner rsp_valid && rsp_ready: increment the owner's done counter and go to IDLE.
  - The other requester's rsp_ready is ignored.
  - Backpressure stalls indefinitely; no req_ready is asserted in CONV or RESP.
- Latency: accept at cycle N gives rsp_valid at N+2. Minimum issue interval is 3 cycles (IDLE, CONV, RESP with immediate ready).
- Fairness: under continuous dual requests, grants alternate A, B, A, B. A single requester may be granted back-to-back.
- Requester obligation: req_data must be stable while req_valid is high and not accepted. Dropping req_valid before acceptance is permitted and carries no penalty.
- Counters wrap from 2^CNT_W−1 to 0 without saturating.
- FPCVT semantics the bench checks against (value = F·2^E):
  - Take the magnitude of D; −4096 maps to 4095.
  - lz = leading zeros of the 12-bit magnitude.
  - If lz≥7: E=0 and F=mag[4:0].
  - Otherwise: E=7−lz, F = the 5 bits below and including the leading one, rounded half-up on the next bit.
  - If F rounds to 32, F becomes 16 and E increments.
  - If E would exceed 7, E=7 and F=31.
  - S is D[12].

Test Plan:
- Reset and single request:
  - Stimulus: reset, then A sends 100 with a_rsp_ready held at 1.
  - Required: a_req_ready=1 in the accept cycle; a_rsp_valid two cycles later with S=0, E=2, F=25; a_done_cnt=1; busy falls the cycle after the handshake.
- Contention:
  - Stimulus: A and B both valid continuously, A=−400 and B=50, both rsp_ready=1.
  - Required: grant order A, B, A, B; A gets S=1, E=4, F=25; B gets S=0, E=1, F=25.
- Saturation:
  - Stimulus: B sends 4095, then −4096.
  - Required: both return E=7, F=31 (S=0 then S=1); sat_cnt=2.
- Backpressure:
  - Stimulus: A sends 13'b0000000001111 with a_rsp_ready=0 for 10 cycles while B is valid.
  - Required: rsp held at S=0, E=0, F=15; b_req_ready stays 0; B is granted only after A's handshake.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously during CONV.
  - Required: all outputs are 0 immediately; after release, the next grant goes to A even if B is also valid.
- Counter wrap:
  - Stimulus: 256 A transactions of operand 0.
  - Required: every result is S=0, E=0, F=0; a_done_cnt returns to 0; b_done_cnt is unchanged.
